// File: rtl/reg_file_sb.sv
// Integer register file with a per-register pending scoreboard.
// NRD combinational read ports, one clocked write port, x0 reads as zero.
// Addresses at or above NREGS behave like x0: they read zero, they are never
// busy, and writes or issues to them have no effect.
//
// Valid semantics: wr_en qualifies wr_addr/wr_data and iss_en qualifies
// iss_rd. Each is sampled on the rising clock edge in which it is high.
// There is no ready/back-pressure: every qualified request takes effect in
// that same edge unless rst is high. Read ports have no valid and are always
// live.
module reg_file_sb #(
  parameter int XLEN   = 64,
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rd
);

  // x0 has no storage; entries 1..NREGS-1 only.
  logic [XLEN-1:0] regs [1:NREGS-1];
  logic [NREGS-1:1] pending;

  // Architectural state: clear on reset, otherwise take the writeback for an in-range non-zero destination.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 1; i < NREGS; i++) begin
        if (wr_addr == AW'(i)) begin
          regs[i] <= wr_data;
        end
      end
    end
  end

  // Scoreboard: writeback clears, then issue sets, so a same-cycle issue to the same register wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (wr_en && (wr_addr == AW'(i))) begin
          pending[i] <= 1'b0;
        end
        if (iss_en && (iss_rd == AW'(i))) begin
          pending[i] <= 1'b1;
        end
      end
    end
  end

  // Read ports: select the addressed register, with an optional bypass from the current writeback.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      for (int i = 1; i < NREGS; i++) begin
        if (rd_addr[k*AW +: AW] == AW'(i)) begin
          rd_data[k*XLEN +: XLEN] = regs[i];
          rd_busy[k]              = pending[i];
          if ((BYPASS != 0) && wr_en && (wr_addr == AW'(i))) begin
            rd_data[k*XLEN +: XLEN] = wr_data;
            rd_busy[k]              = 1'b0;
          end
        end
      end
    end
  end

endmodule
